// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, NOP encoding, fetch FSM states.
// HALT is reachable only when FETCH_ALIGN_CHECK_EN is defined.
package riscv_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ      = 2'd0,
    ESPERA   = 2'd1,
    DESCARTA = 2'd2,
    HALT     = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/busca_instrucao_if.sv
// Instruction memory bus between fetch (master) and memory (slave).
// One request pulse, one later ack strobe carrying the word.
interface busca_instrucao_if #(
  parameter int XLEN = riscv_pkg::XLEN
);

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [31:0]     mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/busca_instrucao.sv
// Fetch stage: PC, single-outstanding memory request, one-entry output buffer.
// FETCH_ALIGN_CHECK_EN adds erro_alinh and halts on misaligned redirects.
module busca_instrucao #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] PC_RESET = riscv_pkg::PC_RESET
) (
  input  logic                clk,
  input  logic                rst,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic                erro_alinh,
`endif
  busca_instrucao_if.master   mem,
  input  logic                redir_valid,
  input  logic [XLEN-1:0]     redir_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [31:0]         instrucao,
  output logic [XLEN-1:0]     instr_pc
);

  import riscv_pkg::*;

  fetch_state_t    state;
  fetch_state_t    state_n;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_n;
  logic [XLEN-1:0] req_pc;
  logic            free;
  logic            redir;
  logic            bad;
  logic            req;
  logic            load;

  assign mem.mem_req  = req && !rst;
  assign mem.mem_addr = pc;

  always_comb begin
    free    = !instr_valid || instr_ready;
    redir   = redir_valid && (state != HALT);
`ifdef FETCH_ALIGN_CHECK_EN
    bad     = redir && (redir_pc[1:0] != 2'b00);
`else
    bad     = 1'b0;
`endif
    state_n = state;
    pc_n    = pc;
    req     = 1'b0;
    load    = 1'b0;
    if (redir) begin
      pc_n = redir_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
      unique case (state)
        ESPERA,
        DESCARTA: state_n = mem.mem_ack ? REQ : DESCARTA;
        default:  state_n = state;
      endcase
      if (bad)
        state_n = HALT;
    end else begin
      unique case (state)
        REQ: begin
          if (free) begin
            req     = 1'b1;
            pc_n    = pc + XLEN'(4);
            state_n = ESPERA;
          end
        end
        ESPERA: begin
          if (mem.mem_ack) begin
            load    = 1'b1;
            state_n = REQ;
          end
        end
        DESCARTA: begin
          if (mem.mem_ack)
            state_n = REQ;
        end
        HALT: state_n = HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= PC_RESET;
      state       <= REQ;
      req_pc      <= '0;
      instr_valid <= 1'b0;
      instrucao   <= NOP;
      instr_pc    <= '0;
    end else begin
      pc    <= pc_n;
      state <= state_n;
      if (req)
        req_pc <= pc;
      // a redirect flushes the buffer even if decode is ready
      if (redir) begin
        instr_valid <= 1'b0;
      end else if (load) begin
        instr_valid <= 1'b1;
        instrucao   <= mem.mem_rdata;
        instr_pc    <= req_pc;
      end else if (instr_valid && instr_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)
      erro_alinh <= 1'b0;
    else if (bad)
      erro_alinh <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: run, backpressure, redirects,
// PC wrap and alignment handling (both FETCH_ALIGN_CHECK_EN builds).
module tb_busca_instrucao;

  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instrucao;
  logic [31:0] instr_pc;

  logic        redir2 = 1'b0;
  logic [31:0] redir_pc2 = '0;
  logic        valid2;
  logic        ready2 = 1'b1;
  logic [31:0] instr2;
  logic [31:0] pc2;

  int checks   = 0;
  int failures = 0;
  int lat      = 1;
  bit stale_en = 1'b0;
  bit outstanding = 1'b0;
  bit saw_stale   = 1'b0;

  always #5 clk = ~clk;

  busca_instrucao_if #(.XLEN(32)) bus ();
  busca_instrucao_if #(.XLEN(32)) bus2 ();

`ifdef FETCH_ALIGN_CHECK_EN
  logic erro;
  logic erro2;
`endif

  busca_instrucao #(.XLEN(32), .PC_RESET(32'h0)) u_dut (
    .clk         (clk),
    .rst         (rst),
`ifdef FETCH_ALIGN_CHECK_EN
    .erro_alinh  (erro),
`endif
    .mem         (bus.master),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instrucao   (instrucao),
    .instr_pc    (instr_pc)
  );

  busca_instrucao #(.XLEN(32), .PC_RESET(32'hFFFF_FFFC)) u_wrap (
    .clk         (clk),
    .rst         (rst),
`ifdef FETCH_ALIGN_CHECK_EN
    .erro_alinh  (erro2),
`endif
    .mem         (bus2.master),
    .redir_valid (redir2),
    .redir_pc    (redir_pc2),
    .instr_valid (valid2),
    .instr_ready (ready2),
    .instrucao   (instr2),
    .instr_pc    (pc2)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h000: word_at = 32'h0031_0133;
      32'h004: word_at = 32'h0001_210B;
      32'h008: word_at = 32'h0123_0003;
      32'h00C: word_at = 32'h00C0_0093;
      32'h040: word_at = 32'h0400_0113;
      32'h080: word_at = 32'h0800_0193;
      32'h100: word_at = 32'h1000_0213;
      default: word_at = {a[23:0], 8'h13};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drv();
    rst = 1'b1;
    redir_valid = 1'b0;
    drv();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp);
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      nx();
      if (bus.mem_req) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
    chk(tag, bus.mem_addr, exp);
  endtask

  task automatic wait_valid(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      nx();
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  // variable-latency instruction memory for the main DUT
  initial begin
    logic [31:0] a;
    int l;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        a = bus.mem_addr;
        l = lat;
        repeat (l) @(posedge clk);
        #1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = stale_en ? 32'hDEAD_BEEF : word_at(a);
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      outstanding = 1'b0;
    end else begin
      if (bus.mem_ack) begin
        chk("ack_without_req", 32'(outstanding), 32'd1);
        outstanding = 1'b0;
      end
      if (bus.mem_req) begin
        chk("second_outstanding", 32'(outstanding), 32'd0);
        outstanding = 1'b1;
      end
      if (instr_valid && instrucao == 32'hDEAD_BEEF)
        saw_stale = 1'b1;
    end
  end

  initial begin
    bus2.mem_ack   = 1'b0;
    bus2.mem_rdata = '0;

    // reset state, then streaming with single-cycle memory
    repeat (2) @(posedge clk);
    nx();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instrucao, NOP);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_erro", 32'(erro), 32'd0);
`endif
    drv();
    rst = 1'b0;
    nx();
    chk("run_req0", 32'(bus.mem_req), 32'd1);
    chk("run_addr0", bus.mem_addr, 32'h0);
    nx();
    chk("run_wait_req", 32'(bus.mem_req), 32'd0);
    chk("run_wait_valid", 32'(instr_valid), 32'd0);
    nx();
    chk("run_v0", 32'(instr_valid), 32'd1);
    chk("run_i0", instrucao, 32'h0031_0133);
    chk("run_p0", instr_pc, 32'h0);
    chk("run_addr1", bus.mem_addr, 32'h4);
    chk("run_req1", 32'(bus.mem_req), 32'd1);
    nx();
    chk("run_gap_valid", 32'(instr_valid), 32'd0);
    nx();
    chk("run_i1", instrucao, 32'h0001_210B);
    chk("run_p1", instr_pc, 32'h4);
    chk("run_addr2", bus.mem_addr, 32'h8);
    nx();
    nx();
    chk("run_v2", 32'(instr_valid), 32'd1);
    chk("run_i2", instrucao, 32'h0123_0003);
    chk("run_p2", instr_pc, 32'h8);
    drv();
    instr_ready = 1'b0;

    // backpressure: hold the first word for 5 cycles
    do_reset();
    nx();
    chk("bp_addr0", bus.mem_addr, 32'h0);
    nx();
    for (int i = 0; i < 5; i++) begin
      nx();
      chk("bp_hold_valid", 32'(instr_valid), 32'd1);
      chk("bp_hold_instr", instrucao, 32'h0031_0133);
      chk("bp_hold_noreq", 32'(bus.mem_req), 32'd0);
    end
    drv();
    instr_ready = 1'b1;
    nx();
    chk("bp_req_after", 32'(bus.mem_req), 32'd1);
    chk("bp_addr_after", bus.mem_addr, 32'h4);
    drv();
    instr_ready = 1'b0;
    nx();
    nx();

    // redirect while waiting on a 3-cycle memory
    lat = 3;
    stale_en = 1'b1;
    do_reset();
    nx();
    chk("esp_addr0", bus.mem_addr, 32'h0);
    drv();
    redir_valid = 1'b1;
    redir_pc = 32'h100;
    drv();
    redir_valid = 1'b0;
    nx();
    chk("esp_discard_noreq", 32'(bus.mem_req), 32'd0);
    wait_req("esp_addr_redir", 32'h100);
    stale_en = 1'b0;
    wait_valid("esp_valid");
    chk("esp_instr", instrucao, word_at(32'h100));
    chk("esp_pc", instr_pc, 32'h100);
    chk("esp_no_stale", 32'(saw_stale), 32'd0);
    lat = 1;

    // redirect on the ack cycle, then on a ready buffered word
    do_reset();
    instr_ready = 1'b1;
    nx();
    chk("ack_addr0", bus.mem_addr, 32'h0);
    drv();
    redir_valid = 1'b1;
    redir_pc = 32'h40;
    nx();
    chk("ack_redir_noreq", 32'(bus.mem_req), 32'd0);
    drv();
    redir_valid = 1'b0;
    nx();
    chk("ack_drop_valid", 32'(instr_valid), 32'd0);
    chk("ack_req40", 32'(bus.mem_req), 32'd1);
    chk("ack_addr40", bus.mem_addr, 32'h40);
    drv();
    drv();
    redir_valid = 1'b1;
    redir_pc = 32'h80;
    nx();
    chk("flush_shown", instrucao, word_at(32'h40));
    chk("flush_noreq", 32'(bus.mem_req), 32'd0);
    drv();
    redir_valid = 1'b0;
    nx();
    chk("flush_valid", 32'(instr_valid), 32'd0);
    chk("flush_addr80", bus.mem_addr, 32'h80);
    chk("flush_req80", 32'(bus.mem_req), 32'd1);
    drv();
    instr_ready = 1'b0;
    wait_valid("flush_valid80");
    chk("flush_instr80", instrucao, word_at(32'h80));
    chk("flush_pc80", instr_pc, 32'h80);

    // PC wrap on the second instance
    do_reset();
    nx();
    chk("wrap_req0", 32'(bus2.mem_req), 32'd1);
    chk("wrap_addr0", bus2.mem_addr, 32'hFFFF_FFFC);
    drv();
    bus2.mem_ack   = 1'b1;
    bus2.mem_rdata = NOP;
    drv();
    bus2.mem_ack = 1'b0;
    nx();
    chk("wrap_req1", 32'(bus2.mem_req), 32'd1);
    chk("wrap_addr1", bus2.mem_addr, 32'h0);
    chk("wrap_pc", pc2, 32'hFFFF_FFFC);
    nx();
    nx();

    // back-to-back redirects, the second one misaligned
    do_reset();
    nx();
    chk("al_addr0", bus.mem_addr, 32'h0);
    drv();
    redir_valid = 1'b1;
    redir_pc = 32'h200;
    drv();
    redir_pc = 32'h102;
    drv();
    redir_valid = 1'b0;
    nx();
`ifdef FETCH_ALIGN_CHECK_EN
    chk("al_erro", 32'(erro), 32'd1);
    chk("al_halt_req", 32'(bus.mem_req), 32'd0);
    drv();
    redir_valid = 1'b1;
    redir_pc = 32'h300;
    drv();
    redir_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nx();
      chk("al_halt_noreq", 32'(bus.mem_req), 32'd0);
      chk("al_halt_novalid", 32'(instr_valid), 32'd0);
    end
    chk("al_erro_sticky", 32'(erro), 32'd1);
    do_reset();
    nx();
    chk("al_erro_clr", 32'(erro), 32'd0);
    chk("al_resume_req", 32'(bus.mem_req), 32'd1);
    chk("al_resume_addr", bus.mem_addr, 32'h0);
`else
    chk("al_req", 32'(bus.mem_req), 32'd1);
    chk("al_addr_masked", bus.mem_addr, 32'h100);
    wait_valid("al_valid");
    chk("al_pc", instr_pc, 32'h100);
`endif

    nx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
